// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_pkg: op encodings, FSM states and counter sizing for muldiv_unit.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_step: one combinational shift-add / restoring-divide iteration.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    fits    = (shifted >= {1'b0, opnd});
    if (is_div) begin
      // Remainder stays below the divisor, so the difference fits in WIDTH bits.
      nxt_hi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], fits};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit: iterative MULT/DIV with HI/LO; define MULDIV_SIGNED_EN to     |
// | enable signed MULT/DIV. Rev 1.0                                            |
// +----------------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULDIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             sgn;
  logic [2*WIDTH-1:0] prod_neg;
`else
  logic             unused_op0;
  assign unused_op0 = op[0];
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
    prod_neg = -{step_hi, step_lo};
`endif
    if (dz_q) begin
      res_hi = a_q;
      res_lo = '1;
    end
`ifdef MULDIV_SIGNED_EN
    else if (!div_q) begin
      if (qneg_q) {res_hi, res_lo} = prod_neg;
    end else begin
      if (qneg_q) res_lo = -step_lo;
      if (rneg_q) res_hi = -step_hi;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    dz_d     = dz_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_mag    = srcA;
    b_mag    = srcB;
`ifdef MULDIV_SIGNED_EN
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    sgn      = op[0];
    if (sgn && srcA[WIDTH-1]) a_mag = -srcA;
    if (sgn && srcB[WIDTH-1]) b_mag = -srcB;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          div_d    = op[1];
          dz_d     = op[1] && (srcB == '0);
          a_d      = srcA;
          acc_hi_d = '0;
          // Multiply walks the multiplier in LO; divide shifts the dividend out of LO.
          acc_lo_d = op[1] ? a_mag : b_mag;
          opnd_d   = op[1] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
          qneg_d   = sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
          rneg_d   = sgn && srcA[WIDTH-1];
`endif
        end else begin
          if (hiWrite) hi_d = srcA;
          if (loWrite) lo_d = srcA;
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULDIV_SIGNED_EN
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        hiWrite = 1'b0;
  logic        loWrite = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc;
  int seen_done;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .hiWrite(hiWrite), .loWrite(loWrite), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edges after the start edge until done rises; -1 if it never does.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    op = o; srcA = a; srcB = b; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd32);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    step();
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    step();

    // MULTU max*max, including done not yet high one edge early
    op = 2'b00; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 31; i++) step();
    chk("mulu_done_early", {31'd0, done}, 32'd0);
    chk("mulu_busy_run", {31'd0, busy}, 32'd1);
    chk("mulu_hi_hold", hi, 32'd0);
    step();
    chk("mulu_done", {31'd0, done}, 32'd1);
    chk("mulu_hi", hi, 32'hFFFFFFFE);
    chk("mulu_lo", lo, 32'h00000001);
    step();
    chk("mulu_busy_after", {31'd0, busy}, 32'd0);
    chk("mulu_done_after", {31'd0, done}, 32'd0);

`ifdef MULDIV_SIGNED_EN
    run_op("mult", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_minneg", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_zero_s", 2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
`else
    run_op("mult", 2'b01, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
    run_op("div_minneg", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
`endif
    run_op("divu", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("divu_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("divu_big", 2'b10, 32'd1000000, 32'd7, 32'd1, 32'd142857);

    // start and hiWrite mid-RUN are ignored
    op = 2'b00; srcA = 32'd2; srcB = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    op = 2'b10; srcA = 32'd100; srcB = 32'd9; start = 1'b1; hiWrite = 1'b1;
    step();
    start = 1'b0; hiWrite = 1'b0;
    chk("midrun_hi_ignored", hi, 32'd1);
    for (int i = 5; i <= 31; i++) step();
    chk("midrun_not_done", {31'd0, done}, 32'd0);
    step();
    chk("midrun_done", {31'd0, done}, 32'd1);
    chk("midrun_hi", hi, 32'd0);
    chk("midrun_lo", lo, 32'd6);
    step();

    // reset at cycle 10 of a RUN abandons the operation
    op = 2'b00; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_run_busy", {31'd0, busy}, 32'd0);
    chk("rst_run_done", {31'd0, done}, 32'd0);
    chk("rst_run_hi", hi, 32'd0);
    chk("rst_run_lo", lo, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) seen_done++;
    end
    chk("rst_run_no_done", 32'(seen_done), 32'd0);

    // MTHI / MTLO in IDLE
    srcA = 32'h12345678; hiWrite = 1'b1;
    step();
    hiWrite = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo_untouched", lo, 32'd0);
    srcA = 32'hA5A5F00F; hiWrite = 1'b1; loWrite = 1'b1;
    step();
    hiWrite = 1'b0; loWrite = 1'b0;
    chk("mthilo_hi", hi, 32'hA5A5F00F);
    chk("mthilo_lo", lo, 32'hA5A5F00F);

    // start wins over a same-cycle loWrite
    op = 2'b00; srcA = 32'h10; srcB = 32'h3; start = 1'b1; loWrite = 1'b1;
    step();
    start = 1'b0; loWrite = 1'b0;
    chk("startwin_lo_kept", lo, 32'hA5A5F00F);
    chk("startwin_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    chk("startwin_lat", 32'(cyc), 32'd32);
    chk("startwin_hi", hi, 32'd0);
    chk("startwin_lo", lo, 32'h30);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
